// File: rtl/inv_shiftrows_stream.sv
// inv_shiftrows_stream: byte-serial AES (Inv)ShiftRows with ping-pong state buffers.
// Bytes are stored unpermuted; the row shift is applied on the read side.
module inv_shiftrows_stream #(
    parameter bit INVERSE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_byte,
    output logic         out_last,
    output logic [127:0] out_state,
    output logic [15:0]  blk_count
);
    logic [127:0] bufs [2];
    logic [1:0]   full, full_nxt;
    logic         wr_sel, rd_sel;
    logic [3:0]   wr_idx, rd_idx;
    logic         in_fire, out_fire;
    logic [127:0] perm;

    function automatic logic [127:0] permute(input logic [127:0] s);
        logic [127:0] p;
        logic [3:0]   kk;
        logic [1:0]   col;
        p = '0;
        for (int k = 0; k < 16; k++) begin
            kk  = 4'(k);
            col = INVERSE ? kk[3:2] - kk[1:0] : kk[3:2] + kk[1:0];
            p[8*k +: 8] = s[8*{col, kk[1:0]} +: 8];
        end
        return p;
    endfunction

    assign in_ready  = !full[wr_sel] && !flush;
    assign out_valid = full[rd_sel];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !flush;
    assign perm      = permute(bufs[rd_sel]);
    assign out_state = out_valid ? perm : '0;
    assign out_byte  = out_state[8*rd_idx +: 8];
    assign out_last  = out_valid && rd_idx == 4'd15;

    // write and read always complete into different buffers, so both updates apply
    always_comb begin
        full_nxt = full;
        if (in_fire && wr_idx == 4'd15) full_nxt[wr_sel] = 1'b1;
        if (out_fire && rd_idx == 4'd15) full_nxt[rd_sel] = 1'b0;
    end

    always_ff @(posedge clk)
        if (in_fire) bufs[wr_sel][8*wr_idx +: 8] <= in_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            blk_count <= '0;
        end else if (flush) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            full <= full_nxt;
            if (in_fire) begin
                wr_idx <= wr_idx + 4'd1;
                if (wr_idx == 4'd15) wr_sel <= !wr_sel;
            end
            if (out_fire) begin
                rd_idx <= rd_idx + 4'd1;
                if (rd_idx == 4'd15) begin
                    rd_sel    <= !rd_sel;
                    blk_count <= blk_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: doc/inv_shiftrows_stream.md
# inv_shiftrows_stream

Byte-serial AES InvShiftRows stage for the decryption datapath. Accepts the 16 bytes of a state over a valid/ready byte stream, applies the inverse cyclic row shift, and re-emits the permuted state byte-serially, plus a parallel 128-bit copy. Two ping-pong state buffers allow one block to be received while the previous one is transmitted. The block sits between the inverse-cipher byte pipeline and the InvSubBytes/AddRoundKey stages.

## Interface
- INVERSE, default 1: 1 = InvShiftRows; 0 = forward ShiftRows, used for encrypt/decrypt loopback checks.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; clears both buffers and all counters.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  stage can accept a byte.
- in_byte  in  8  state byte; the k-th byte of a block lands at state bits [8k+7:8k].
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer accepts out_byte.
- out_byte  out  8  permuted state byte k, k = 0..15.
- out_last  out  1  high with out_byte k = 15.
- out_state  out  128  full permuted state of the block being transmitted.
- blk_count  out  16  number of blocks fully transmitted, wraps modulo 2^16.

## Operation
- State layout: byte index k = 4c + r, where c is the column (0..3) and r is the row (0..3).
- Permutation:
  - INVERSE=1: out[r,c] = in[r,(c−r) mod 4].
  - INVERSE=0: out[r,c] = in[r,(c+r) mod 4].
- Buffers: two 128-bit buffers B0/B1, each with a full flag. Pointers wr_sel and rd_sel, and 4-bit counters wr_idx and rd_idx.
- Write side:
  - in_ready = !full[wr_sel] && !flush.
  - A byte is accepted when in_valid && in_ready; it is stored at B[wr_sel] byte wr_idx, and wr_idx increments.
  - On acceptance with wr_idx == 15: set full[wr_sel], toggle wr_sel, wrap wr_idx to 0.
- Read side:
  - out_valid = full[rd_sel].
  - out_byte = B[rd_sel] byte src(rd_idx), where src is the permutation above. The permutation is applied on read; stored data stays unpermuted.
  - out_state = permute(B[rd_sel]), stable while out_valid.
  - A byte transfers when out_valid && out_ready, and rd_idx increments.
  - On transfer with rd_idx == 15: clear full[rd_sel], toggle rd_sel, wrap rd_idx to 0, increment blk_count.
- Simultaneous events:
  - Completing a write into one buffer and completing a read from the other in the same cycle are both honoured.
  - The same buffer is never written and read at once, because a full buffer blocks writes.
- Both buffers full: in_ready = 0. Backpressure holds until one buffer drains.
- Flush: both full flags, both pointers, wr_idx and rd_idx go to 0. blk_count is kept. A partial block is discarded. A transfer offered in the flush cycle is ignored.
- Reset: same as flush, and additionally blk_count = 0. Reset asserted mid-block discards everything.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_byte = 0, out_state = 0, blk_count = 0.
  - out_byte and out_state are forced to 0 whenever out_valid = 0.
- Latency: out_valid rises on the cycle after the 16th input byte is accepted. Byte 0 is available in that cycle.
- Throughput: 1 byte/cycle sustained in both directions with out_ready held high. No bubble between blocks.
- Handshake:
  - While out_valid && !out_ready, out_byte, out_last and out_state stay stable.
  - in_ready does not depend combinationally on in_valid.
  - out_valid does not depend on out_ready.
- blk_count updates on the clock edge where the last byte transfers.

## Test plan
- Bytes 0x00..0x0F in, INVERSE=1, out_ready=1 -> out = 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03. Also out_state = 0x0306090C0F0205080B0E0104070A0D00, out_last on the 16th byte, blk_count = 1.
- Same input with INVERSE=0 -> out = 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B.
- Three back-to-back blocks with out_ready=0 -> in_ready drops after 32 accepted bytes. After releasing out_ready, all 48 bytes come out correct and in order, and blk_count = 3.
- Random in_valid/out_ready toggling across 1000 random blocks -> output matches a reference InvShiftRows model, with no byte lost or duplicated.
- Flush after 7 bytes of block 2, with block 1 pending -> out_valid = 0 next cycle, in_ready = 1, blk_count unchanged. The next 16 bytes form a clean block.
- rst_n pulsed low asynchronously mid-transmit (rd_idx = 9) -> all outputs go to reset values immediately. After release, the stage accepts a fresh block normally.
